// File: rtl/proc8_isa_pkg.sv
// ISA constants shared by the 8-bit pipeline stages: opcodes, instruction
// field positions and the decode-stage FSM encoding.
package proc8_isa_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_LI   = 3'b100;
   localparam logic [2:0] OP_BEQ  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam int OPC_HI = 7;
   localparam int OPC_LO = 5;
   localparam int RD_HI  = 4;
   localparam int RD_LO  = 3;
   localparam int RS_HI  = 2;
   localparam int RS_LO  = 1;
   localparam int IMM_HI = 2;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_REDIR = 2'd1,
      ST_HALT  = 2'd2
   } id_state_e;

   // Only ALU ops and stores read GPRs in ID; control flow never does.
   function automatic logic reads_gpr(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/id_stage_hazard.sv
// Load-use detector: the instruction in IF/ID reads a register that the LW
// currently sitting in ID/EX has not yet produced.
module hazard_unit
   import proc8_isa_pkg::*;
(
   input  logic       if_valid,
   input  logic [2:0] if_opcode,
   input  logic [1:0] if_rd,
   input  logic [1:0] if_rs,
   input  logic       ex_valid,
   input  logic [2:0] ex_opcode,
   input  logic [1:0] ex_rd,
   output logic       stall
);

   always_comb begin
      stall = if_valid && reads_gpr(if_opcode) &&
              ex_valid && (ex_opcode == OP_LW) &&
              ((ex_rd == if_rd) || (ex_rd == if_rs));
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decode into a registered ID/EX bundle, fetch
// redirect (jump/branch/stall refetch/halt self-loop) and the RUN/REDIR/HALT FSM.
module id_stage
   import proc8_isa_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int INST_W = 8,
   parameter int OFF_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [INST_W-1:0] inst,
   input  logic [ADDR_W-1:0] pc_calc,
   input  logic              zero_flag,
   output logic [ADDR_W-1:0] pcj_mux,
   output logic              choice_mux,
   output logic              ex_valid,
   output logic [2:0]        ex_opcode,
   output logic [1:0]        ex_rd,
   output logic [1:0]        ex_rs,
   output logic [7:0]        ex_imm,
   output logic [ADDR_W-1:0] ex_pc,
   output logic              halted
);

   typedef struct packed {
      logic              valid;
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] pc;
   } if_id_t;

   typedef struct packed {
      logic              valid;
      logic [2:0]        opcode;
      logic [1:0]        rd;
      logic [1:0]        rs;
      logic [7:0]        imm;
      logic [ADDR_W-1:0] pc;
   } id_ex_t;

   if_id_t            if_id;
   id_ex_t            id_ex, id_ex_nxt;
   id_state_e         state, state_nxt;
   logic              stall, if_hold, if_flush, issue;
   logic [2:0]        id_op;
   logic [1:0]        id_rd, id_rs;
   logic [OFF_W-1:0]  id_off;
   logic [ADDR_W-1:0] jmp_target, br_target;

   assign id_op  = if_id.inst[OPC_HI:OPC_LO];
   assign id_rd  = if_id.inst[RD_HI:RD_LO];
   assign id_rs  = if_id.inst[RS_HI:RS_LO];
   assign id_off = if_id.inst[OFF_W-1:0];

   // id_pc is already fetch addr + 1, so both targets are relative to it.
   assign jmp_target = {if_id.pc[ADDR_W-1:OFF_W], id_off};
   assign br_target  = if_id.pc + {{(ADDR_W-OFF_W){id_off[OFF_W-1]}}, id_off};

   hazard_unit u_hazard (
      .if_valid  (if_id.valid),
      .if_opcode (id_op),
      .if_rd     (id_rd),
      .if_rs     (id_rs),
      .ex_valid  (id_ex.valid),
      .ex_opcode (id_ex.opcode),
      .ex_rd     (id_ex.rd),
      .stall     (stall)
   );

   always_comb begin
      state_nxt  = state;
      choice_mux = 1'b0;
      pcj_mux    = '0;
      if_hold    = 1'b0;
      if_flush   = 1'b0;
      issue      = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (if_id.valid) begin
               if (id_op == OP_HALT) begin
                  state_nxt  = ST_HALT;
                  choice_mux = 1'b1;
                  pcj_mux    = if_id.pc - ADDR_W'(1);
                  if_hold    = 1'b1;
               end else if (stall) begin
                  // Refetch the slot behind the held reader.
                  choice_mux = 1'b1;
                  pcj_mux    = if_id.pc;
                  if_hold    = 1'b1;
               end else if (id_op == OP_JMP) begin
                  state_nxt  = ST_REDIR;
                  choice_mux = 1'b1;
                  pcj_mux    = jmp_target;
                  if_flush   = 1'b1;
               end else if ((id_op == OP_BEQ) && zero_flag) begin
                  state_nxt  = ST_REDIR;
                  choice_mux = 1'b1;
                  pcj_mux    = br_target;
                  if_flush   = 1'b1;
               end else begin
                  // Not-taken BEQ has no EX work and leaves as a bubble.
                  issue = (id_op != OP_BEQ);
               end
            end
         end
         ST_REDIR: state_nxt = ST_RUN;
         ST_HALT: begin
            choice_mux = 1'b1;
            pcj_mux    = if_id.pc - ADDR_W'(1);
            if_hold    = 1'b1;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      id_ex_nxt = '0;
      if (issue) begin
         id_ex_nxt.valid  = 1'b1;
         id_ex_nxt.opcode = id_op;
         id_ex_nxt.rd     = id_rd;
         id_ex_nxt.rs     = id_rs;
         id_ex_nxt.imm    = {5'd0, if_id.inst[IMM_HI:IMM_LO]};
         id_ex_nxt.pc     = if_id.pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_RUN;
         if_id <= '0;
         id_ex <= '0;
      end else begin
         state <= state_nxt;
         id_ex <= id_ex_nxt;
         if (if_flush) begin
            if_id <= '0;
         end else if (!if_hold) begin
            if_id.valid <= 1'b1;
            if_id.inst  <= inst;
            if_id.pc    <= pc_calc;
         end
      end
   end

   assign ex_valid  = id_ex.valid;
   assign ex_opcode = id_ex.opcode;
   assign ex_rd     = id_ex.rd;
   assign ex_rs     = id_ex.rs;
   assign ex_imm    = id_ex.imm;
   assign ex_pc     = id_ex.pc;
   assign halted    = (state == ST_HALT);

endmodule
